// File: rtl/bypass_regfile_pkg.sv
// bypass_regfile_pkg: default sizes and fixed architectural indices for the bypassing register file
package bypass_regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF = 2;
  localparam int NWR_DEF = 2;
  localparam int X1_IDX = 1;
  localparam int X10_IDX = 10;
endpackage

// File: rtl/bypass_regfile_if.sv
// bypass_regfile_if: read/write-back/issue/flush bus; master drives requests, slave returns data, busy, pend_cnt, x1_r, endcode
interface bypass_regfile_if
  import bypass_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = NRD_DEF,
  parameter int NWR = NWR_DEF
);
  localparam int IDXW = $clog2(NREG);
  localparam int CNTW = $clog2(NREG + 1);
  logic [NRD*IDXW-1:0] rd_idx;
  logic [NRD*XLEN-1:0] rd_dat;
  logic [NRD-1:0] rd_busy;
  logic [NWR-1:0] wr_en;
  logic [NWR*IDXW-1:0] wr_idx;
  logic [NWR*XLEN-1:0] wr_dat;
  logic iss_en;
  logic [IDXW-1:0] iss_idx;
  logic flush;
  logic [CNTW-1:0] pend_cnt;
  logic [XLEN-1:0] x1_r;
  logic [XLEN-1:0] endcode;
  modport master (
    output rd_idx, wr_en, wr_idx, wr_dat, iss_en, iss_idx, flush,
    input rd_dat, rd_busy, pend_cnt, x1_r, endcode
  );
  modport slave (
    input rd_idx, wr_en, wr_idx, wr_dat, iss_en, iss_idx, flush,
    output rd_dat, rd_busy, pend_cnt, x1_r, endcode
  );
endinterface

// File: rtl/bypass_regfile_rd_port.sv
// regfile_rd_port: one read port with same-cycle write bypass (highest write port wins), x0 forced to zero
module regfile_rd_port
  import bypass_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int IDXW = 5,
  parameter int NWR = NWR_DEF
) (
  input  logic [IDXW-1:0]     idx,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*IDXW-1:0] wr_idx,
  input  logic [NWR*XLEN-1:0] wr_dat,
  input  logic [XLEN-1:0]     stored,
  input  logic                pend,
  output logic [XLEN-1:0]     dat,
  output logic                busy
);
  logic hit;
  logic [XLEN-1:0] byp;
  always_comb begin
    hit = 1'b0;
    byp = stored;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wr_idx[w*IDXW +: IDXW] == idx) begin
        hit = 1'b1;
        byp = wr_dat[w*XLEN +: XLEN];
      end
    dat = idx == '0 ? '0 : byp;
    busy = pend & ~hit;
  end
endmodule

// File: rtl/bypass_regfile.sv
// bypass_regfile: multi-port register file with write bypass and pending-producer scoreboard
module bypass_regfile
  import bypass_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = NRD_DEF,
  parameter int NWR = NWR_DEF
) (
  input logic clk,
  input logic rst,
  bypass_regfile_if.slave bus
);
  localparam int IDXW = $clog2(NREG);
  localparam int CNTW = $clog2(NREG + 1);
  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0] pend_q, pend_d, wb_hit;
  logic [CNTW-1:0] cnt_q, cnt_d;
  always_comb begin
    regs_d = regs_q;
    wb_hit = '0;
    for (int w = 0; w < NWR; w++)
      if (bus.wr_en[w] && bus.wr_idx[w*IDXW +: IDXW] != '0) begin
        regs_d[bus.wr_idx[w*IDXW +: IDXW]] = bus.wr_dat[w*XLEN +: XLEN];
        wb_hit[bus.wr_idx[w*IDXW +: IDXW]] = 1'b1;
      end
    pend_d = bus.flush ? '0 : pend_q & ~wb_hit;
    if (bus.iss_en && bus.iss_idx != '0) pend_d[bus.iss_idx] = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) cnt_d = cnt_d + CNTW'(pend_d[i]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regs_q <= '0;
      pend_q <= '0;
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
    end
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [IDXW-1:0] idx;
    assign idx = bus.rd_idx[p*IDXW +: IDXW];
    regfile_rd_port #(.XLEN(XLEN), .IDXW(IDXW), .NWR(NWR)) u_rd (
      .idx(idx),
      .wr_en(bus.wr_en),
      .wr_idx(bus.wr_idx),
      .wr_dat(bus.wr_dat),
      .stored(regs_q[idx]),
      .pend(pend_q[idx]),
      .dat(bus.rd_dat[p*XLEN +: XLEN]),
      .busy(bus.rd_busy[p])
    );
  end
  assign bus.pend_cnt = cnt_q;
  assign bus.x1_r = regs_q[X1_IDX];
  assign bus.endcode = NREG > X10_IDX ? regs_q[X10_IDX % NREG] : '0;
endmodule

// File: tb/tb_bypass_regfile.sv
// tb_bypass_regfile: directed and random checks of bypass_regfile against an array-based reference model
module tb_bypass_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mreg [32];
  logic mpend [32];
  int total = 0;
  int passed = 0;
  bypass_regfile_if bus ();
  bypass_regfile dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wi0, input logic [31:0] wd0,
                       input logic [4:0] wi1, input logic [31:0] wd1, input logic ie,
                       input logic [4:0] ii, input logic fl, input logic [4:0] r0, input logic [4:0] r1);
    bus.wr_en = we;
    bus.wr_idx = {wi1, wi0};
    bus.wr_dat = {wd1, wd0};
    bus.iss_en = ie;
    bus.iss_idx = ii;
    bus.flush = fl;
    bus.rd_idx = {r1, r0};
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, r0, r1);
  endtask

  task automatic model_reset;
    for (int i = 0; i < 32; i++) begin
      mreg[i] = '0;
      mpend[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) if (mpend[i]) c++;
    return c;
  endfunction

  task automatic check_all(input string tag);
    logic [4:0] ri;
    logic [31:0] d;
    logic b;
    #1;
    for (int p = 0; p < 2; p++) begin
      ri = bus.rd_idx[p*5 +: 5];
      d = ri == 0 ? 32'd0 : mreg[ri];
      b = ri != 0 && mpend[ri];
      for (int w = 0; w < 2; w++)
        if (ri != 0 && bus.wr_en[w] && bus.wr_idx[w*5 +: 5] == ri) begin
          d = bus.wr_dat[w*32 +: 32];
          b = 1'b0;
        end
      check($sformatf("%s/rd_dat%0d", tag, p), 64'(bus.rd_dat[p*32 +: 32]), 64'(d));
      check($sformatf("%s/rd_busy%0d", tag, p), 64'(bus.rd_busy[p]), 64'(b));
    end
    check({tag, "/pend_cnt"}, 64'(bus.pend_cnt), 64'(model_count()));
    check({tag, "/x1_r"}, 64'(bus.x1_r), 64'(mreg[1]));
    check({tag, "/endcode"}, 64'(bus.endcode), 64'(mreg[10]));
  endtask

  task automatic tick;
    @(posedge clk);
    if (!rst) begin
      for (int w = 0; w < 2; w++)
        if (bus.wr_en[w] && bus.wr_idx[w*5 +: 5] != 0) mreg[bus.wr_idx[w*5 +: 5]] = bus.wr_dat[w*32 +: 32];
      for (int i = 0; i < 32; i++) begin
        if (bus.flush) mpend[i] = 1'b0;
        for (int w = 0; w < 2; w++) if (bus.wr_en[w] && bus.wr_idx[w*5 +: 5] == i) mpend[i] = 1'b0;
      end
      if (bus.iss_en && bus.iss_idx != 0) mpend[bus.iss_idx] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    idle(5'd1, 5'd10);
    tick();
    tick();
    check_all("reset");
    rst = 1'b0;
    // write then read
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
    check_all("wr_byp");
    check("wr_byp_const", 64'(bus.rd_dat[31:0]), 64'h0000_0000_DEAD_BEEF);
    tick();
    idle(5'd5, 5'd0);
    check_all("wr_stored");
    check("wr_stored_const", 64'(bus.rd_dat[31:0]), 64'h0000_0000_DEAD_BEEF);
    // dual-write collision
    drive(2'b11, 5'd3, 32'h11, 5'd3, 32'h22, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
    check_all("coll_byp");
    check("coll_byp_const", 64'(bus.rd_dat[63:32]), 64'h22);
    tick();
    idle(5'd3, 5'd5);
    check_all("coll_stored");
    check("coll_stored_const", 64'(bus.rd_dat[31:0]), 64'h22);
    // x0 rule
    drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    check_all("x0_byp");
    check("x0_byp_const", 64'(bus.rd_dat[31:0]), 64'd0);
    tick();
    idle(5'd0, 5'd0);
    check_all("x0_after");
    check("x0_busy_const", 64'(bus.rd_busy), 64'd0);
    check("x0_cnt_const", 64'(bus.pend_cnt), 64'd0);
    // scoreboard
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
    check_all("sb_iss");
    tick();
    idle(5'd7, 5'd0);
    check_all("sb_pend");
    check("sb_busy_const", 64'(bus.rd_busy[0]), 64'd1);
    check("sb_cnt_const", 64'(bus.pend_cnt), 64'd1);
    drive(2'b01, 5'd7, 32'h77, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
    check_all("sb_iss_wb");
    tick();
    idle(5'd7, 5'd0);
    check_all("sb_still");
    check("sb_still_busy_const", 64'(bus.rd_busy[0]), 64'd1);
    check("sb_still_cnt_const", 64'(bus.pend_cnt), 64'd1);
    drive(2'b10, 5'd0, 32'd0, 5'd7, 32'h78, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
    check_all("sb_wb");
    tick();
    idle(5'd7, 5'd0);
    check_all("sb_clear");
    check("sb_clear_busy_const", 64'(bus.rd_busy[0]), 64'd0);
    check("sb_clear_cnt_const", 64'(bus.pend_cnt), 64'd0);
    // flush with a same-cycle issue
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 5'd2, 5'd4);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd2, 5'd4);
    tick();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 5'd2, 5'd4);
    tick();
    idle(5'd2, 5'd6);
    check_all("fl_pre");
    check("fl_pre_cnt_const", 64'(bus.pend_cnt), 64'd3);
    drive(2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd2, 5'd6);
    check_all("fl_cyc");
    tick();
    idle(5'd9, 5'd2);
    check_all("fl_post");
    check("fl_cnt_const", 64'(bus.pend_cnt), 64'd1);
    check("fl_busy_const", 64'(bus.rd_busy), 64'b01);
    idle(5'd4, 5'd6);
    check_all("fl_post2");
    check("fl_busy2_const", 64'(bus.rd_busy), 64'b00);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom), 5'($urandom_range(0, 11)), $urandom, 5'($urandom_range(0, 11)), $urandom,
            1'($urandom), 5'($urandom_range(0, 11)), $urandom_range(0, 15) == 0,
            5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
      check_all("rand");
      tick();
    end
    // asynchronous reset mid-cycle
    drive(2'b11, 5'd1, 32'hAAAA, 5'd10, 32'h5555, 1'b1, 5'd4, 1'b0, 5'd1, 5'd10);
    tick();
    idle(5'd1, 5'd4);
    check_all("rst_pre");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_rd_dat", 64'(bus.rd_dat), 64'd0);
    check("rst_busy", 64'(bus.rd_busy), 64'd0);
    check("rst_cnt", 64'(bus.pend_cnt), 64'd0);
    check("rst_x1", 64'(bus.x1_r), 64'd0);
    check("rst_endcode", 64'(bus.endcode), 64'd0);
    @(negedge clk);
    drive(2'b01, 5'd1, 32'h1234, 5'd0, 32'd0, 1'b1, 5'd1, 1'b0, 5'd1, 5'd10);
    tick();
    idle(5'd1, 5'd10);
    check_all("rst_wr_ignored");
    rst = 1'b0;
    tick();
    drive(2'b01, 5'd10, 32'hC0DE, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd1);
    tick();
    idle(5'd10, 5'd1);
    check_all("post_rst");
    check("post_rst_endcode_const", 64'(bus.endcode), 64'hC0DE);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
